// File: rtl/bnn_axi_pkg.sv
// Shared AXI read-master constants and state encoding
// for the BNN accelerator memory front end.
package bnn_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned AXI_4K_BYTES = 4096;
  localparam int unsigned AXI_4K_WORDS = AXI_4K_BYTES / 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_WAIT_SPACE,
    ST_ADDR,
    ST_DATA,
    ST_FIN
  } rd_state_e;

endpackage

// File: rtl/bnn_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count,
// shared by the BNN streaming stages.
module bnn_sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // A pop at full frees the slot the push lands in.
  assign w_push = i_push && (!w_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(i_push && w_full && !i_pop));
  end

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read master: splits a word request into 4 KB-safe INCR
// bursts and streams returned beats to the BNN core.
module axi_burst_reader #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arqos,
  output logic [3:0]        m_axi_arregion,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  import bnn_axi_pkg::*;

  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         r_state;
  rd_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rem;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_bcnt;
  logic [CW-1:0]     r_resv;
  logic              r_err;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;

  logic [10:0]       w_bnd_words;
  logic [31:0]       w_min;
  logic [LEN_W-1:0]  w_len;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_free;
  logic              w_space_ok;
  logic              w_empty;
  logic              w_beat;
  logic              w_last;
  logic              w_beat_err;
  logic              w_burst_end;
  logic [CNT_W-1:0]  w_rem_after;

  assign m_axi_arsize   = AXI_SIZE_4B;
  assign m_axi_arburst  = AXI_BURST_INCR;
  assign m_axi_arcache  = AXI_CACHE_DEFAULT;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arqos    = 4'h0;
  assign m_axi_arregion = 4'h0;
  assign m_axi_araddr   = r_araddr;
  assign m_axi_arlen    = r_arlen;
  assign m_axi_arvalid  = (r_state == ST_ADDR);
  assign m_axi_rready   = (r_state == ST_DATA);

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_err;
  assign out_valid = !w_empty;

  // Words left before the next 4 KB page.
  assign w_bnd_words = 11'(AXI_4K_WORDS) - {1'b0, r_addr[11:2]};

  always_comb begin
    w_min = 32'(r_rem);
    if (w_min > 32'(MAX_BURST))   w_min = 32'(MAX_BURST);
    if (w_min > 32'(w_bnd_words)) w_min = 32'(w_bnd_words);
  end
  assign w_len = LEN_W'(w_min);

  assign w_free     = CW'(FIFO_DEPTH) - w_count - r_resv;
  assign w_space_ok = (w_free >= CW'(r_len));

  assign w_beat      = (r_state == ST_DATA) && m_axi_rvalid;
  assign w_last      = (r_bcnt == LEN_W'(1));
  assign w_beat_err  = (m_axi_rresp != AXI_RESP_OKAY) ||
                       (m_axi_rlast != w_last);
  // An early rlast also closes the burst; the slave sends no more.
  assign w_burst_end = w_beat && (w_last || m_axi_rlast);
  assign w_rem_after = r_rem - CNT_W'(r_len);

  bnn_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_push  (w_beat),
    .i_data  (m_axi_rdata),
    .i_pop   (out_valid && out_ready),
    .o_data  (out_data),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start)
          w_next = (num_words == '0) ? ST_FIN : ST_CALC;
      end
      ST_CALC:       w_next = ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (w_space_ok) w_next = ST_ADDR;
      ST_ADDR:       if (m_axi_arready) w_next = ST_DATA;
      ST_DATA: begin
        if (w_burst_end) begin
          if (w_rem_after == '0 || r_err || w_beat_err)
            w_next = ST_FIN;
          else
            w_next = ST_CALC;
        end
      end
      ST_FIN:        if (w_empty) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr   <= '0;
      r_rem    <= '0;
      r_len    <= '0;
      r_bcnt   <= '0;
      r_resv   <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_araddr <= '0;
      r_arlen  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (1'b1)
        r_state == ST_IDLE: begin
          if (start) begin
            r_addr <= base_addr;
            r_rem  <= num_words;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        r_state == ST_CALC: r_len <= w_len;
        r_state == ST_WAIT_SPACE: begin
          if (w_space_ok) begin
            r_resv   <= CW'(r_len);
            r_bcnt   <= r_len;
            r_araddr <= r_addr;
            r_arlen  <= 8'(r_len - LEN_W'(1));
          end
        end
        r_state == ST_DATA: begin
          if (w_beat) begin
            r_bcnt <= r_bcnt - LEN_W'(1);
            if (w_beat_err) r_err <= 1'b1;
          end
          if (w_burst_end) begin
            r_addr <= r_addr + ADDR_W'({r_len, 2'b00});
            r_rem  <= w_rem_after;
            r_resv <= '0;
          end
        end
        r_state == ST_FIN: begin
          if (w_empty) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Randomized bench for axi_burst_reader against a burst-plan
// and word-stream reference model with an AXI slave model.
module tb_axi_burst_reader;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_words;
  logic        busy, done, error;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arlock;
  logic [3:0]  arqos, arregion;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  burst_t      exp_ar[$];
  int exp_nb, exp_nw, ar_cnt, out_cnt, gbeat, err_beat;
  bit full;
  int rdy_mode;

  axi_burst_reader dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .m_axi_araddr   (araddr),
    .m_axi_arlen    (arlen),
    .m_axi_arsize   (arsize),
    .m_axi_arburst  (arburst),
    .m_axi_arcache  (arcache),
    .m_axi_arprot   (arprot),
    .m_axi_arlock   (arlock),
    .m_axi_arqos    (arqos),
    .m_axi_arregion (arregion),
    .m_axi_arvalid  (arvalid),
    .m_axi_arready  (arready),
    .m_axi_rdata    (rdata),
    .m_axi_rresp    (rresp),
    .m_axi_rlast    (rlast),
    .m_axi_rvalid   (rvalid),
    .m_axi_rready   (rready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_3C3C ^ {a[15:0], a[31:16]};
  endfunction

  // Reference plan: page-safe bursts, truncated after an error burst.
  task automatic plan(input logic [31:0] base, input int n,
                      input int eb);
    logic [31:0] a;
    int rem, len, idx, room;
    bit stop;
    exp_q.delete();
    exp_ar.delete();
    a = base; rem = n; idx = 0; stop = 0;
    while (rem > 0 && !stop) begin
      room = (4096 - int'(a % 4096)) / 4;
      len = rem;
      if (len > 16) len = 16;
      if (len > room) len = room;
      exp_ar.push_back('{a, len});
      for (int i = 0; i < len; i++)
        exp_q.push_back(mem_word(a + 32'(4 * i)));
      if (eb >= idx && eb < idx + len) stop = 1;
      idx += len;
      a += 32'(4 * len);
      rem -= len;
    end
    exp_nb = exp_ar.size();
    exp_nw = exp_q.size();
    ar_cnt = 0; out_cnt = 0; gbeat = 0; err_beat = eb;
  endtask

  task automatic start_xfer(input logic [31:0] base, input int n,
                            input int eb);
    plan(base, n, eb);
    start = 1'b1;
    base_addr = base;
    num_words = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    bit got;
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(got), 1);
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_words"}, 32'(out_cnt), 32'(exp_nw));
    chk({tag, "_bursts"}, 32'(ar_cnt), 32'(exp_nb));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_arvalid"}, 32'(arvalid), 0);
    chk({tag, "_rready"}, 32'(rready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_arlen"}, 32'(arlen), 0);
  endtask

  // AXI slave: decisions at negedge, handshakes land on next posedge.
  initial begin : slave
    burst_t pq[$];
    int bi;
    bit act, hs, aw;
    logic [31:0] pa;
    logic [7:0] pl;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    bi = 0; act = 0; hs = 0; aw = 0; pa = 0; pl = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pq.delete();
        bi = 0; act = 0; hs = 0; aw = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0;
        continue;
      end
      if (hs) begin
        bi++;
        gbeat++;
        if (bi == pq[0].len) begin
          void'(pq.pop_front());
          bi = 0;
          act = 0;
        end
      end
      if (!act && pq.size() > 0) act = 1;
      if (act) begin
        chk("rready_hold", 32'(rready), 1);
        rvalid = full ? 1'b1 : ($urandom_range(3) != 0);
        rdata  = mem_word(pq[0].addr + 32'(4 * bi));
        rlast  = (bi == pq[0].len - 1);
        rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 0; rlast = 0; rresp = 0;
      end
      hs = rvalid && rready;
      if (aw && arvalid) begin
        chk("araddr_stable", araddr, pa);
        chk("arlen_stable", 32'(arlen), 32'(pl));
      end
      arready = full ? 1'b1 : ($urandom_range(2) == 0);
      aw = arvalid && !arready;
      pa = araddr;
      pl = arlen;
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) begin
          chk("ar_count", 32'(ar_cnt + 1), 32'(exp_nb));
        end else begin
          chk("araddr", araddr, exp_ar[0].addr);
          chk("arlen", 32'(arlen), 32'(exp_ar[0].len - 1));
          void'(exp_ar.pop_front());
        end
        pq.push_back('{araddr, int'(arlen) + 1});
        ar_cnt++;
      end
    end
  end

  initial begin : sink
    out_ready = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        out_ready = 0;
        continue;
      end
      unique case (rdy_mode)
        0:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(1) == 1);
      endcase
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("out_count", 32'(out_cnt + 1), 32'(exp_nw));
        else
          chk("out_data", out_data, exp_q.pop_front());
        out_cnt++;
      end
    end
  end

  initial begin
    logic [31:0] b;
    bit reached;
    resetn = 0; start = 0; base_addr = 0; num_words = 0;
    full = 1; rdy_mode = 0; err_beat = -1;
    exp_nb = 0; exp_nw = 0; ar_cnt = 0; out_cnt = 0; gbeat = 0;
    @(negedge clk);
    chk_idle_outs("rst");
    chk("rst_arsize", 32'(arsize), 32'h2);
    chk("rst_arburst", 32'(arburst), 32'h1);
    chk("rst_arcache", 32'(arcache), 32'h3);
    @(posedge clk); #2 resetn = 1;
    @(negedge clk);

    start_xfer(32'h1000_0000, 63, -1);
    repeat (10) @(negedge clk);
    start = 1; base_addr = 32'h2000_0000; num_words = 5;
    @(negedge clk);
    start = 0;
    wait_done("t1", 0);

    full = 0; rdy_mode = 1;
    start_xfer(32'h1000_0FF8, 8, -1);
    wait_done("t2", 0);

    rdy_mode = 2;
    start_xfer(32'h3000_0100, 20, -1);
    repeat (150) @(negedge clk);
    chk("t3_ar_stall", 32'(ar_cnt), 2);
    chk("t3_no_out", 32'(out_cnt), 0);
    chk("t3_busy", 32'(busy), 1);
    chk("t3_valid", 32'(out_valid), 1);
    rdy_mode = 1;
    wait_done("t3", 0);

    start_xfer(32'h4000_0000, 40, 2);
    wait_done("t4", 1);
    chk("t4_sticky", 32'(error), 1);
    start_xfer(32'h4000_2000, 5, -1);
    chk("t4_err_clr", 32'(error), 0);
    wait_done("t4b", 0);

    plan(32'h0, 0, -1);
    start = 1; base_addr = 32'h7000_0000; num_words = 0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_done_early", 32'(done), 0);
    base_addr = 32'h7000_1000; num_words = 7;
    @(negedge clk);
    start = 0;
    chk("t5_done", 32'(done), 1);
    chk("t5_busy_drop", 32'(busy), 0);
    @(negedge clk);
    chk("t5_ignored", 32'(busy), 0);
    chk("t5_no_ar", 32'(ar_cnt), 0);

    for (int k = 0; k < 4; k++) begin
      b = 32'h5000_0F00 + 32'($urandom_range(0, 63) * 4);
      start_xfer(b, int'($urandom_range(1, 50)), -1);
      wait_done("t6", 0);
    end

    start_xfer(32'h6000_0000, 40, -1);
    reached = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (gbeat >= 5) begin
        reached = 1;
        break;
      end
    end
    chk("t7_reached", 32'(reached), 1);
    #3 resetn = 0;
    #1 chk_idle_outs("t7");
    repeat (2) @(negedge clk);
    @(posedge clk); #2 resetn = 1;
    @(negedge clk);
    start_xfer(32'h6000_0100, 5, -1);
    wait_done("t7b", 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
